// File: rtl/video_scanout.sv
// rtl/video_scanout.sv - video timing generator and palettised pixel sink
//
// Scans a framebuffer through the video bus. A pixel enable is derived from
// the system clock, the h/v counters advance on it, and each pixel position is
// presented to the bus for CLK_DIV clocks. The returned colour is captured on
// the following pixel enable, together with the delayed de/hsync/vsync.
//
// Optional feature macro: VIDEO_SCANOUT_DOUBLE_SCAN_EN
//   defined     : each source line is shown on two output lines (line = v >> 1)
//   not defined : one output line per source line (line = v)
//
// Ports:
//   i_clock          system clock
//   i_reset_n        asynchronous active-low reset
//   o_video_request  scan window active (line or prefetch)
//   o_video_pos_x    requested pixel column
//   o_video_pos_y    requested source line
//   i_video_rdata    0x00RRGGBB for the previous position, one clock later
//   o_vga_r/g/b      pixel colour, zero outside the active area
//   o_vga_de         data enable
//   o_vga_hsync      horizontal sync, active-low
//   o_vga_vsync      vertical sync, active-low
//   o_frame_start    one-clock pulse when position (0,0) is presented

module video_scanout #(
   parameter int CLK_DIV  = 4,
   parameter int H_ACTIVE = 320,
   parameter int H_FRONT  = 8,
   parameter int H_SYNC   = 48,
   parameter int H_BACK   = 24,
   parameter int V_ACTIVE = 200,
   parameter int V_FRONT  = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BACK   = 33,
   parameter int PREFETCH = 8
) (
   input  logic        i_clock,
   input  logic        i_reset_n,
   output logic        o_video_request,
   output logic [8:0]  o_video_pos_x,
   output logic [8:0]  o_video_pos_y,
   input  logic [31:0] i_video_rdata,
   output logic [7:0]  o_vga_r,
   output logic [7:0]  o_vga_g,
   output logic [7:0]  o_vga_b,
   output logic        o_vga_de,
   output logic        o_vga_hsync,
   output logic        o_vga_vsync,
   output logic        o_frame_start
);

   localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
   localparam int DW = $clog2(CLK_DIV);
   localparam int HW = $clog2(H_TOTAL);
   localparam int VW = $clog2(V_TOTAL);

   // Comparison constants carry one spare bit so a region end equal to the
   // total count still fits.
   localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV - 1);
   localparam logic [HW-1:0] H_LAST    = HW'(H_TOTAL - 1);
   localparam logic [VW-1:0] V_LAST    = VW'(V_TOTAL - 1);
   localparam logic [HW:0]   H_ACT_C   = (HW+1)'(H_ACTIVE);
   localparam logic [HW:0]   H_SS_C    = (HW+1)'(H_ACTIVE + H_FRONT);
   localparam logic [HW:0]   H_SE_C    = (HW+1)'(H_ACTIVE + H_FRONT + H_SYNC);
   localparam logic [HW:0]   H_PF_C    = (HW+1)'(H_TOTAL - PREFETCH);
   localparam logic [VW:0]   V_ACT_C   = (VW+1)'(V_ACTIVE);
   localparam logic [VW:0]   V_SS_C    = (VW+1)'(V_ACTIVE + V_FRONT);
   localparam logic [VW:0]   V_SE_C    = (VW+1)'(V_ACTIVE + V_FRONT + V_SYNC);

   logic [DW-1:0] div_q, div_d;
   logic [HW-1:0] h_q, h_d;
   logic [VW-1:0] v_q, v_d;
   logic          req_q, req_d;
   logic [8:0]    pos_x_q, pos_x_d;
   logic [8:0]    pos_y_q, pos_y_d;
   // First stage: decode of the presented position, aligned with pos_x/pos_y.
   logic          de_s1_q, de_s1_d;
   logic          hs_s1_q, hs_s1_d;
   logic          vs_s1_q, vs_s1_d;
   // Second stage: display outputs, one pixel behind the position.
   logic [7:0]    r_q, r_d, g_q, g_d, b_q, b_d;
   logic          de_q, de_d, hs_q, hs_d, vs_q, vs_d;
   logic          fs_q, fs_d;

   logic          pix_en;
   logic          h_wrap, v_wrap;
   logic [VW-1:0] vnext;
   logic [HW:0]   h_ext;
   logic [VW:0]   v_ext, vn_ext;
   logic [8:0]    line_v, line_vn;
   logic          line_win, pf_win;
   logic          unused_rdata;

   assign unused_rdata = ^i_video_rdata[31:24];

   assign pix_en = (div_q == DIV_LAST);
   assign h_wrap = (h_q == H_LAST);
   assign v_wrap = (v_q == V_LAST);
   assign vnext  = v_wrap ? '0 : v_q + 1'b1;
   assign h_ext  = {1'b0, h_q};
   assign v_ext  = {1'b0, v_q};
   assign vn_ext = {1'b0, vnext};

`ifdef VIDEO_SCANOUT_DOUBLE_SCAN_EN
   assign line_v   = 9'(v_q >> 1);
   assign line_vn  = 9'(vnext >> 1);
   // Odd output lines repeat the source line already fetched for the even one.
   assign pf_win   = (h_ext >= H_PF_C) && (vn_ext < V_ACT_C) && !vnext[0];
`else
   assign line_v   = 9'(v_q);
   assign line_vn  = 9'(vnext);
   assign pf_win   = (h_ext >= H_PF_C) && (vn_ext < V_ACT_C);
`endif
   assign line_win = (v_ext < V_ACT_C) && (h_ext < H_ACT_C);

   always_comb begin
      div_d   = pix_en ? '0 : div_q + 1'b1;
      h_d     = h_q;
      v_d     = v_q;
      req_d   = req_q;
      pos_x_d = pos_x_q;
      pos_y_d = pos_y_q;
      de_s1_d = de_s1_q;
      hs_s1_d = hs_s1_q;
      vs_s1_d = vs_s1_q;
      r_d     = r_q;
      g_d     = g_q;
      b_d     = b_q;
      de_d    = de_q;
      hs_d    = hs_q;
      vs_d    = vs_q;
      fs_d    = pix_en && (h_q == '0) && (v_q == '0);

      if (pix_en) begin
         if (h_wrap) begin
            h_d = '0;
            v_d = vnext;
         end else begin
            h_d = h_q + 1'b1;
         end

         // Present the current counter position to the bus.
         req_d   = line_win || pf_win;
         pos_x_d = line_win ? 9'(h_q) : 9'd0;
         if (line_win) begin
            pos_y_d = line_v;
         end else if (pf_win) begin
            pos_y_d = line_vn;
         end
         de_s1_d = line_win;
         hs_s1_d = !((h_ext >= H_SS_C) && (h_ext < H_SE_C));
         vs_s1_d = !((v_ext >= V_SS_C) && (v_ext < V_SE_C));

         // Colour for the position presented during the pixel just ending.
         r_d  = de_s1_q ? i_video_rdata[23:16] : 8'd0;
         g_d  = de_s1_q ? i_video_rdata[15:8]  : 8'd0;
         b_d  = de_s1_q ? i_video_rdata[7:0]   : 8'd0;
         de_d = de_s1_q;
         hs_d = hs_s1_q;
         vs_d = vs_s1_q;
      end
   end

   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         div_q   <= '0;
         h_q     <= '0;
         v_q     <= '0;
         req_q   <= 1'b0;
         pos_x_q <= 9'd0;
         pos_y_q <= 9'd0;
         de_s1_q <= 1'b0;
         hs_s1_q <= 1'b1;
         vs_s1_q <= 1'b1;
         r_q     <= 8'd0;
         g_q     <= 8'd0;
         b_q     <= 8'd0;
         de_q    <= 1'b0;
         hs_q    <= 1'b1;
         vs_q    <= 1'b1;
         fs_q    <= 1'b0;
      end else begin
         div_q   <= div_d;
         h_q     <= h_d;
         v_q     <= v_d;
         req_q   <= req_d;
         pos_x_q <= pos_x_d;
         pos_y_q <= pos_y_d;
         de_s1_q <= de_s1_d;
         hs_s1_q <= hs_s1_d;
         vs_s1_q <= vs_s1_d;
         r_q     <= r_d;
         g_q     <= g_d;
         b_q     <= b_d;
         de_q    <= de_d;
         hs_q    <= hs_d;
         vs_q    <= vs_d;
         fs_q    <= fs_d;
      end
   end

   assign o_video_request = req_q;
   assign o_video_pos_x   = pos_x_q;
   assign o_video_pos_y   = pos_y_q;
   assign o_vga_r         = r_q;
   assign o_vga_g         = g_q;
   assign o_vga_b         = b_q;
   assign o_vga_de        = de_q;
   assign o_vga_hsync     = hs_q;
   assign o_vga_vsync     = vs_q;
   assign o_frame_start   = fs_q;

endmodule

// File: tb/tb_video_scanout.sv
// tb/tb_video_scanout.sv - directed checks for video_scanout
//
// dut_a: CLK_DIV 4, H 16/2/4/2 (total 24), V 6/1/2/1 (total 10), PREFETCH 3.
// dut_b: CLK_DIV 2, default horizontal timing, V 4/1/1/1, PREFETCH 8.
// Position of pixel p (frame-linear index since reset) is visible from
// cycle (p+1)*CLK_DIV, its display outputs from cycle (p+2)*CLK_DIV.

module tb_video_scanout;
   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int cyc;
   int checks = 0;
   int errors = 0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) cyc <= 0;
      else        cyc <= cyc + 1;
   end

   logic        req_a, de_a, hs_a, vs_a, fs_a;
   logic [8:0]  x_a, y_a;
   logic [7:0]  r_a, g_a, b_a;
   logic [31:0] rd_a = 32'd0;
   logic        req_b, de_b, hs_b, vs_b, fs_b;
   logic [8:0]  x_b, y_b;
   logic [7:0]  r_b, g_b, b_b;
   logic [31:0] rd_b = 32'd0;

   // Palette bus model: registered colour one clock after the position.
   always @(posedge clk) rd_a <= {8'h00, x_a[7:0], y_a[7:0], 8'hA5};
   always @(posedge clk) rd_b <= {8'h00, x_b[7:0], y_b[7:0], 8'hA5};

   video_scanout #(
      .CLK_DIV(4), .H_ACTIVE(16), .H_FRONT(2), .H_SYNC(4), .H_BACK(2),
      .V_ACTIVE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(1), .PREFETCH(3)
   ) dut_a (
      .i_clock(clk), .i_reset_n(rst_n),
      .o_video_request(req_a), .o_video_pos_x(x_a), .o_video_pos_y(y_a),
      .i_video_rdata(rd_a),
      .o_vga_r(r_a), .o_vga_g(g_a), .o_vga_b(b_a),
      .o_vga_de(de_a), .o_vga_hsync(hs_a), .o_vga_vsync(vs_a),
      .o_frame_start(fs_a)
   );

   video_scanout #(
      .CLK_DIV(2), .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1)
   ) dut_b (
      .i_clock(clk), .i_reset_n(rst_n),
      .o_video_request(req_b), .o_video_pos_x(x_b), .o_video_pos_y(y_b),
      .i_video_rdata(rd_b),
      .o_vga_r(r_b), .o_vga_g(g_b), .o_vga_b(b_b),
      .o_vga_de(de_b), .o_vga_hsync(hs_b), .o_vga_vsync(vs_b),
      .o_frame_start(fs_b)
   );

   // Position vectors for dut_a, frame 0: h, v, request, pos_x, pos_y.
   int pos_h [13] = '{0, 5, 15, 16, 20, 21, 23, 0, 5, 21, 0, 20, 21};
   int pos_v [13] = '{0, 0, 2, 2, 2, 2, 2, 3, 3, 5, 9, 9, 9};
   int pos_x [13] = '{0, 5, 15, 0, 0, 0, 0, 0, 5, 0, 0, 0, 0};
`ifdef VIDEO_SCANOUT_DOUBLE_SCAN_EN
   int pos_r [13] = '{1, 1, 1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 1};
   int pos_y [13] = '{0, 0, 1, 1, 1, 1, 1, 1, 1, 2, 2, 2, 0};
   int dsp_g [11] = '{0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0};
   int line3      = 1;
`else
   int pos_r [13] = '{1, 1, 1, 0, 0, 1, 1, 1, 1, 0, 0, 0, 1};
   int pos_y [13] = '{0, 0, 2, 2, 2, 3, 3, 3, 3, 5, 5, 5, 0};
   int dsp_g [11] = '{0, 2, 0, 0, 0, 0, 3, 0, 0, 0, 0};
   int line3      = 3;
`endif

   // Display vectors for dut_a, frame 1: h, v, de, r, g, b, hsync, vsync.
   int dsp_h  [11] = '{0, 15, 16, 18, 21, 22, 5, 0, 0, 3, 0};
   int dsp_v  [11] = '{0, 2, 2, 2, 2, 2, 3, 6, 7, 8, 9};
   int dsp_de [11] = '{1, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0};
   int dsp_r  [11] = '{0, 15, 0, 0, 0, 0, 5, 0, 0, 0, 0};
   int dsp_b  [11] = '{165, 165, 0, 0, 0, 0, 165, 0, 0, 0, 0};
   int dsp_hs [11] = '{1, 1, 1, 0, 0, 1, 1, 1, 1, 1, 1};
   int dsp_vs [11] = '{1, 1, 1, 1, 1, 1, 1, 1, 0, 0, 1};

   task automatic wait_cyc(input int k);
      int guard = 0;
      while (cyc < k && guard < 20000) begin
         @(negedge clk);
         guard++;
      end
      if (cyc != k) begin
         errors++;
         $display("FAIL wait_cyc: cyc %0d required %0d", cyc, k);
      end
   endtask

   task automatic test_reset;
      repeat (3) @(negedge clk);
      checks++;
      if ({req_a, x_a, y_a, r_a, g_a, b_a, de_a, hs_a, vs_a, fs_a} !==
          {1'b0, 9'd0, 9'd0, 8'd0, 8'd0, 8'd0, 1'b0, 1'b1, 1'b1, 1'b0}) begin
         errors++;
         $display("FAIL reset_values: req %b x %0d y %0d rgb %h%h%h de %b hs %b vs %b fs %b required 0 0 0 000000 0 1 1 0",
                  req_a, x_a, y_a, r_a, g_a, b_a, de_a, hs_a, vs_a, fs_a);
      end
      rst_n = 1'b1;
      wait_cyc(3);
      checks++;
      if (req_a !== 1'b0) begin
         errors++;
         $display("FAIL first_pixel_early: req %b required 0", req_a);
      end
   endtask

   task automatic test_position;
      for (int i = 0; i < 13; i++) begin
         wait_cyc((pos_v[i] * 24 + pos_h[i] + 1) * 4);
         checks++;
         if (req_a !== 1'(pos_r[i]) || x_a !== 9'(pos_x[i]) || y_a !== 9'(pos_y[i])) begin
            errors++;
            $display("FAIL position h%0d v%0d: req %b x %0d y %0d required %0d %0d %0d",
                     pos_h[i], pos_v[i], req_a, x_a, y_a, pos_r[i], pos_x[i], pos_y[i]);
         end
      end
   endtask

   task automatic test_display;
      for (int i = 0; i < 11; i++) begin
         wait_cyc((240 + dsp_v[i] * 24 + dsp_h[i] + 2) * 4);
         checks++;
         if (de_a !== 1'(dsp_de[i]) || r_a !== 8'(dsp_r[i]) || g_a !== 8'(dsp_g[i]) ||
             b_a !== 8'(dsp_b[i])) begin
            errors++;
            $display("FAIL pixel h%0d v%0d: de %b rgb %h %h %h required %0d %h %h %h",
                     dsp_h[i], dsp_v[i], de_a, r_a, g_a, b_a, dsp_de[i],
                     8'(dsp_r[i]), 8'(dsp_g[i]), 8'(dsp_b[i]));
         end
         checks++;
         if (hs_a !== 1'(dsp_hs[i]) || vs_a !== 1'(dsp_vs[i])) begin
            errors++;
            $display("FAIL sync h%0d v%0d: hs %b vs %b required %0d %0d",
                     dsp_h[i], dsp_v[i], hs_a, vs_a, dsp_hs[i], dsp_vs[i]);
         end
      end
   endtask

   task automatic test_clk_div2;
      // Line v=3 of dut_b: pixel index 1200+h, each held for two clocks.
      for (int h = 0; h < 320; h++) begin
         for (int k = 0; k < 2; k++) begin
            wait_cyc((1200 + h + 1) * 2 + k);
            checks++;
            if (req_b !== 1'b1 || x_b !== 9'(h)) begin
               errors++;
               $display("FAIL div2_x h%0d clk%0d: req %b x %0d required 1 %0d", h, k, req_b, x_b, h);
            end
         end
      end
      checks++;
      if (y_b !== 9'(line3)) begin
         errors++;
         $display("FAIL div2_y: y %0d required %0d", y_b, line3);
      end
      wait_cyc((1200 + 320 + 1) * 2);
      checks++;
      if (req_b !== 1'b0 || x_b !== 9'd0) begin
         errors++;
         $display("FAIL div2_blank: req %b x %0d required 0 0", req_b, x_b);
      end
   endtask

   task automatic test_frame_start;
      int highs = 0;
      int last  = -1;
      wait_cyc(3843);
      checks++;
      if (fs_a !== 1'b0) begin errors++; $display("FAIL fs_before: fs %b required 0", fs_a); end
      wait_cyc(3844);
      checks++;
      if (fs_a !== 1'b1) begin errors++; $display("FAIL fs_pulse: fs %b required 1", fs_a); end
      wait_cyc(3845);
      checks++;
      if (fs_a !== 1'b0) begin errors++; $display("FAIL fs_after: fs %b required 0", fs_a); end
      for (int c = 3846; c <= 4805; c++) begin
         wait_cyc(c);
         if (fs_a === 1'b1) begin
            highs++;
            last = c;
         end
      end
      checks++;
      if (highs != 1 || last != 4804) begin
         errors++;
         $display("FAIL fs_period: pulses %0d at %0d required 1 at 4804", highs, last);
      end
   endtask

   task automatic test_reset_mid;
      // Frame 6, position (10,4): request and de are both high.
      wait_cyc((1440 + 4 * 24 + 10 + 1) * 4);
      checks++;
      if (req_a !== 1'b1 || x_a !== 9'd10 || de_a !== 1'b1) begin
         errors++;
         $display("FAIL mid_pre: req %b x %0d de %b required 1 10 1", req_a, x_a, de_a);
      end
      #1 rst_n = 1'b0;
      #1;
      checks++;
      if (req_a !== 1'b0 || x_a !== 9'd0 || de_a !== 1'b0 || hs_a !== 1'b1 || vs_a !== 1'b1) begin
         errors++;
         $display("FAIL mid_reset: req %b x %0d de %b hs %b vs %b required 0 0 0 1 1",
                  req_a, x_a, de_a, hs_a, vs_a);
      end
      @(negedge clk);
      rst_n = 1'b1;
      wait_cyc(4);
      checks++;
      if (req_a !== 1'b1 || x_a !== 9'd0 || y_a !== 9'd0) begin
         errors++;
         $display("FAIL restart_origin: req %b x %0d y %0d required 1 0 0", req_a, x_a, y_a);
      end
      wait_cyc(24);
      checks++;
      if (x_a !== 9'd5) begin
         errors++;
         $display("FAIL restart_x5: x %0d required 5", x_a);
      end
      // Display of (19,7): both syncs low until reset forces them high.
      wait_cyc((7 * 24 + 19 + 2) * 4);
      checks++;
      if (hs_a !== 1'b0 || vs_a !== 1'b0) begin
         errors++;
         $display("FAIL sync_pre: hs %b vs %b required 0 0", hs_a, vs_a);
      end
      #1 rst_n = 1'b0;
      #1;
      checks++;
      if (hs_a !== 1'b1 || vs_a !== 1'b1 || fs_a !== 1'b0) begin
         errors++;
         $display("FAIL sync_reset: hs %b vs %b fs %b required 1 1 0", hs_a, vs_a, fs_a);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      test_reset();
      test_position();
      test_display();
      test_clk_div2();
      test_frame_start();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
